// File: rtl/i8088_bus_pkg.sv
// Shared definitions for the 8088 minimum-mode bus responder.
// Holds the responder state encoding and the bus and wait-counter widths.
package i8088_bus_pkg;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DECODED,
    READ,
    WRITE
  } resp_state_t;

endpackage

// File: rtl/i8088_mem_responder_if.sv
// 8088 minimum-mode bus bundle as seen by one peripheral window.
// Data is a shared tri-state net. oe mirrors the responder's drive enable.
// READY exists only when I8088_WAIT_STATE_EN is defined.
interface i8088_mem_responder_if;
  import i8088_bus_pkg::*;

  logic              ALE;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] Address;
  wire  [DATA_W-1:0] Data;
  logic              oe;
`ifdef I8088_WAIT_STATE_EN
  logic              READY;

  modport master (output ALE, IOM, RD, WR, Address, inout Data, input oe, READY);
  modport slave  (input ALE, IOM, RD, WR, Address, inout Data, output oe, READY);
`else
  modport master (output ALE, IOM, RD, WR, Address, inout Data, input oe);
  modport slave  (input ALE, IOM, RD, WR, Address, inout Data, output oe);
`endif

endinterface

// File: rtl/i8088_byte_ram.sv
// Byte RAM backing one responder window.
// Writes are synchronous. Reads are registered, so rdata changes only on a read enable.
// Contents are deliberately left uninitialised and are not touched by reset.
module i8088_byte_ram
  import i8088_bus_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Single-port array: write commit and registered read share one address
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/i8088_mem_responder.sv
// Peripheral end of the 8088 minimum-mode bus.
// It decodes the window on ALE and serves RD/WR strobes from a byte RAM.
// It drives Data only while a selected read is in progress.
// BASE_ADDR must be aligned to 2**SIZE_LOG2.
// Optional feature: defining I8088_WAIT_STATE_EN adds the READY wait-state handshake.
module i8088_mem_responder
  import i8088_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h00000,
  parameter int                SIZE_LOG2   = 12,
  parameter bit                IS_IO       = 1'b0,
  parameter int                WAIT_CYCLES = 2
) (
  input logic                  CLK,
  input logic                  RESET,
  i8088_mem_responder_if.slave bus
);

  if (SIZE_LOG2 < 1 || SIZE_LOG2 > 16 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_params
    $error("i8088_mem_responder: SIZE_LOG2 or WAIT_CYCLES out of range");
  end

  resp_state_t          state;
  logic                 oe;
  logic                 sel;
  logic [SIZE_LOG2-1:0] offset;
  logic [DATA_W-1:0]    rdata;
  logic [DATA_W-1:0]    wdata;
  logic                 hit;
  logic                 acc_start;
  logic                 rd_en;
  logic                 wr_capture;
  logic                 wr_en;
  logic                 ready_ok;

  // The offset is exactly SIZE_LOG2 bits, so an access cannot leave the window
  assign hit = (bus.Address[ADDR_W-1:SIZE_LOG2] == BASE_ADDR[ADDR_W-1:SIZE_LOG2]) &&
               (bus.IOM != IS_IO);

  // A strobe is accepted only in DECODED, without ALE, and with exactly one strobe low
  assign acc_start  = (state == DECODED) && sel && !bus.ALE && (bus.RD != bus.WR);
  assign rd_en      = acc_start && !bus.RD;
  assign wr_capture = (acc_start && !bus.WR) || ((state == WRITE) && !bus.WR);
  assign wr_en      = (state == WRITE) && bus.WR && ready_ok;

  // Bus-cycle FSM: decode on ALE, then run one read or one write per cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      oe     <= 1'b0;
      sel    <= 1'b0;
      offset <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ALE) begin
            offset <= bus.Address[SIZE_LOG2-1:0];
            sel    <= hit;
            state  <= hit ? DECODED : IDLE;
          end
        end
        DECODED: begin
          if (bus.ALE) begin
            offset <= bus.Address[SIZE_LOG2-1:0];
            sel    <= hit;
            state  <= hit ? DECODED : IDLE;
          end else if (!bus.RD && bus.WR) begin
            state <= READ;
            oe    <= 1'b1;
          end else if (!bus.WR && bus.RD) begin
            state <= WRITE;
          end else if (!bus.RD && !bus.WR) begin
            state <= IDLE;
            sel   <= 1'b0;
          end
        end
        READ: begin
          if (bus.RD) begin
            state <= IDLE;
            oe    <= 1'b0;
            sel   <= 1'b0;
          end
        end
        WRITE: begin
          if (bus.WR) begin
            state <= IDLE;
            sel   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the bus value on every low WR cycle; the last one is what gets committed
  always_ff @(posedge CLK) begin
    if (wr_capture) wdata <= bus.Data;
  end

`ifdef I8088_WAIT_STATE_EN
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);

  logic                  ready_q;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  acc_end;

  assign acc_end = ((state == READ) && bus.RD) || ((state == WRITE) && bus.WR);

  // Hold READY low for WAIT_CYCLES cycles after a strobe is accepted; an early release ends the wait
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ready_q  <= 1'b1;
      wait_cnt <= '0;
    end else if (acc_start && (WAIT_CYCLES != 0)) begin
      ready_q  <= 1'b0;
      wait_cnt <= WAIT_LAST;
    end else if (!ready_q) begin
      if (acc_end || (wait_cnt == '0)) ready_q <= 1'b1;
      else                             wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign ready_ok  = ready_q;
  assign bus.READY = ready_q;
`else
  assign ready_ok = 1'b1;
`endif

  i8088_byte_ram #(
    .AW (SIZE_LOG2)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (offset),
    .wdata (wdata),
    .rdata (rdata)
  );

  // oe is cleared by the asynchronous reset, so Data is released without waiting for a clock
  assign bus.Data = oe ? rdata : {DATA_W{1'bz}};
  assign bus.oe   = oe;

endmodule

// File: tb/tb_i8088_mem_responder.sv
// Directed bench for i8088_mem_responder.
// Two windows share the same stimulus:
//   - a 4 KiB memory window at 20'h01000;
//   - a 256-byte I/O window at 20'h00300.
// Drive is observed through each window's oe, and read data through its Data net.
module tb_i8088_mem_responder;
  import i8088_bus_pkg::*;

`ifdef I8088_WAIT_STATE_EN
  localparam int WH = 4;  // WR low edges: entry plus the three wait cycles
  localparam int RH = 5;
`else
  localparam int WH = 1;
  localparam int RH = 2;
`endif

  logic              clk;
  logic              rst_n;
  logic              ale;
  logic              iom;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic              tb_oe;
  logic [DATA_W-1:0] tb_dat;
  int                checks;
  int                failures;

  i8088_mem_responder_if bus_m ();
  i8088_mem_responder_if bus_io ();

  assign bus_m.ALE      = ale;
  assign bus_m.IOM      = iom;
  assign bus_m.RD       = rd;
  assign bus_m.WR       = wr;
  assign bus_m.Address  = addr;
  assign bus_m.Data     = tb_oe ? tb_dat : 8'hzz;
  assign bus_io.ALE     = ale;
  assign bus_io.IOM     = iom;
  assign bus_io.RD      = rd;
  assign bus_io.WR      = wr;
  assign bus_io.Address = addr;
  assign bus_io.Data    = tb_oe ? tb_dat : 8'hzz;

  i8088_mem_responder #(
    .BASE_ADDR   (20'h01000),
    .SIZE_LOG2   (12),
    .IS_IO       (1'b0),
    .WAIT_CYCLES (3)
  ) dut_mem (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_m)
  );

  i8088_mem_responder #(
    .BASE_ADDR   (20'h00300),
    .SIZE_LOG2   (8),
    .IS_IO       (1'b1),
    .WAIT_CYCLES (3)
  ) dut_io (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic io_cyc_n,
                           input logic [DATA_W-1:0] d, input int hold, input string tag);
    ale = 1'b1; addr = a; iom = io_cyc_n;
    tick();
    ale = 1'b0; tb_oe = 1'b1; tb_dat = d; wr = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_wr_nodrive_m"}, bus_m.oe, 1'b0);
      chk({tag, "_wr_nodrive_io"}, bus_io.oe, 1'b0);
    end
    wr = 1'b1;
    tick();
    tb_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, input logic io_cyc_n,
                          input logic exp_m, input logic exp_io,
                          input logic [DATA_W-1:0] exp_d, input int hold, input string tag);
    ale = 1'b1; addr = a; iom = io_cyc_n;
    tick();
    ale = 1'b0; rd = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_oe_m"}, bus_m.oe, exp_m);
      chk({tag, "_oe_io"}, bus_io.oe, exp_io);
      if (exp_m)  chk({tag, "_data_m"}, bus_m.Data, exp_d);
      if (exp_io) chk({tag, "_data_io"}, bus_io.Data, exp_d);
`ifdef I8088_WAIT_STATE_EN
      if (exp_m) chk({tag, "_ready"}, bus_m.READY, (i < 3) ? 1'b0 : 1'b1);
`endif
    end
    rd = 1'b1;
    tick();
    chk({tag, "_release_m"}, bus_m.oe, 1'b0);
    chk({tag, "_release_io"}, bus_io.oe, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; ale = 1'b0; iom = 1'b1; rd = 1'b1; wr = 1'b1;
    addr = '0; tb_oe = 1'b0; tb_dat = '0;
    repeat (2) tick();
    chk("reset_oe_m", bus_m.oe, 1'b0);
    chk("reset_oe_io", bus_io.oe, 1'b0);
`ifdef I8088_WAIT_STATE_EN
    chk("reset_ready", bus_m.READY, 1'b1);
`endif
    rst_n = 1'b1;
    tick();

    // Write then read back through the memory window
    bus_write(20'h01234, 1'b1, 8'hA5, WH, "wr_1234");
    bus_read(20'h01234, 1'b1, 1'b1, 1'b0, 8'hA5, RH, "rd_1234");

    // First and last byte of the window
    bus_write(20'h01000, 1'b1, 8'h5A, WH, "wr_first");
    bus_write(20'h01FFF, 1'b1, 8'hC3, WH, "wr_last");
    bus_read(20'h01000, 1'b1, 1'b1, 1'b0, 8'h5A, RH, "rd_first");
    bus_read(20'h01FFF, 1'b1, 1'b1, 1'b0, 8'hC3, RH, "rd_last");

    // Out of window: no drive, no RAM change at the aliased offset
    bus_read(20'h02000, 1'b1, 1'b0, 1'b0, 8'h00, RH, "rd_outside");
    bus_write(20'h00FFF, 1'b1, 8'h3C, WH, "wr_outside");
    bus_read(20'h01FFF, 1'b1, 1'b1, 1'b0, 8'hC3, RH, "rd_after_outside");

    // ALE together with RD low: re-decode first, read on the following edge
    ale = 1'b1; addr = 20'h01234; iom = 1'b1;
    tick();
    addr = 20'h01FFF; rd = 1'b0;
    tick();
    chk("ale_wins_nodrive", bus_m.oe, 1'b0);
    ale = 1'b0;
    tick();
    chk("ale_wins_oe", bus_m.oe, 1'b1);
    chk("ale_wins_data", bus_m.Data, 8'hC3);
    rd = 1'b1;
    tick();
    chk("ale_wins_release", bus_m.oe, 1'b0);

    // Both strobes low: abandoned cycle, RAM keeps its old value
    bus_write(20'h01010, 1'b1, 8'h11, WH, "wr_1010");
    ale = 1'b1; addr = 20'h01010; iom = 1'b1;
    tick();
    ale = 1'b0; rd = 1'b0; wr = 1'b0; tb_oe = 1'b1; tb_dat = 8'hEE;
    tick();
    chk("illegal_nodrive", bus_m.oe, 1'b0);
    rd = 1'b1; wr = 1'b1;
    tick();
    tb_oe = 1'b0;
    chk("illegal_after", bus_m.oe, 1'b0);
    bus_read(20'h01010, 1'b1, 1'b1, 1'b0, 8'h11, RH, "rd_1010");

    // I/O versus memory cycles
    bus_write(20'h00345, 1'b0, 8'h5C, WH, "io_wr");
    bus_read(20'h00345, 1'b1, 1'b0, 1'b0, 8'h00, RH, "mem_rd_io_addr");
    bus_read(20'h00345, 1'b0, 1'b0, 1'b1, 8'h5C, RH, "io_rd");
    bus_read(20'h01234, 1'b0, 1'b0, 1'b0, 8'h00, RH, "io_rd_mem_addr");

    // Reset while driving: release is asynchronous, RAM survives
    bus_write(20'h01100, 1'b1, 8'h3E, WH, "wr_1100");
    ale = 1'b1; addr = 20'h01100; iom = 1'b1;
    tick();
    ale = 1'b0; rd = 1'b0;
    tick();
    chk("rst_rd_oe", bus_m.oe, 1'b1);
    chk("rst_rd_data", bus_m.Data, 8'h3E);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_release", bus_m.oe, 1'b0);
`ifdef I8088_WAIT_STATE_EN
    chk("rst_ready", bus_m.READY, 1'b1);
`endif
    rd = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    chk("rst_idle_nodrive", bus_m.oe, 1'b0);
    bus_read(20'h01100, 1'b1, 1'b1, 1'b0, 8'h3E, RH, "rd_after_rst");

`ifdef I8088_WAIT_STATE_EN
    // WR released while READY is still low: the write is dropped
    bus_write(20'h01234, 1'b1, 8'h77, 2, "wr_abort");
    chk("abort_ready", bus_m.READY, 1'b1);
    bus_read(20'h01234, 1'b1, 1'b1, 1'b0, 8'hA5, RH, "rd_after_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
